// File: rtl/imu_i2c_pkg.sv
// Shared encodings, ADXL345 register map, sequencer states and step-list bounds
// for the accelerometer poll sequencer and its command ROM.
package imu_i2c_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    // Step indices: INIT is two 5-command writes, POLL is a 12-command burst read
    localparam logic [3:0] INIT_LAST_STEP = 4'd9;
    localparam logic [3:0] POLL_RD_FIRST  = 4'd5;
    localparam logic [3:0] POLL_RD_LAST   = 4'd10;
    localparam logic [3:0] POLL_LAST_STEP = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_POLL    = 3'd3,
        ST_ABORT   = 3'd4,
        ST_PUBLISH = 3'd5
    } state_e;

    typedef enum logic {
        PH_INIT = 1'b0,
        PH_POLL = 1'b1
    } phase_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/imu_cmd_rom.sv
// Command ROM: maps (phase, step) to the I2C byte-engine command for that step,
// including the read NACK flag and the end-of-list marker.
module imu_cmd_rom
    import imu_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR        = 7'h53,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0] POWER_CTL_VAL   = 8'h08
) (
    input  phase_e     phase_i,
    input  logic [3:0] step_i,
    output logic [1:0] op_o,
    output logic [7:0] wdata_o,
    output logic       nack_o,
    output logic       last_o
);

    localparam logic [7:0] ADDR_WR = {DEV_ADDR, 1'b0};
    localparam logic [7:0] ADDR_RD = {DEV_ADDR, 1'b1};

    // Table lookup; any out-of-range step decodes to a terminating STOP
    always_comb begin
        op_o    = OP_STOP;
        wdata_o = 8'h00;
        nack_o  = 1'b0;
        last_o  = 1'b1;
        if (phase_i == PH_INIT) begin
            case (step_i)
                4'd0, 4'd5: begin op_o = OP_START; last_o = 1'b0; end
                4'd1, 4'd6: begin op_o = OP_WRITE; wdata_o = ADDR_WR; last_o = 1'b0; end
                4'd2:       begin op_o = OP_WRITE; wdata_o = REG_DATA_FORMAT; last_o = 1'b0; end
                4'd3:       begin op_o = OP_WRITE; wdata_o = DATA_FORMAT_VAL; last_o = 1'b0; end
                4'd4:       begin op_o = OP_STOP; last_o = 1'b0; end
                4'd7:       begin op_o = OP_WRITE; wdata_o = REG_POWER_CTL; last_o = 1'b0; end
                4'd8:       begin op_o = OP_WRITE; wdata_o = POWER_CTL_VAL; last_o = 1'b0; end
                INIT_LAST_STEP: begin op_o = OP_STOP; last_o = 1'b1; end
                default:    begin op_o = OP_STOP; last_o = 1'b1; end
            endcase
        end else begin
            case (step_i)
                4'd0, 4'd3: begin op_o = OP_START; last_o = 1'b0; end
                4'd1:       begin op_o = OP_WRITE; wdata_o = ADDR_WR; last_o = 1'b0; end
                4'd2:       begin op_o = OP_WRITE; wdata_o = REG_DATAX0; last_o = 1'b0; end
                4'd4:       begin op_o = OP_WRITE; wdata_o = ADDR_RD; last_o = 1'b0; end
                4'd6, 4'd7, 4'd8, 4'd9, POLL_RD_FIRST: begin op_o = OP_READ; last_o = 1'b0; end
                POLL_RD_LAST:   begin op_o = OP_READ; nack_o = 1'b1; last_o = 1'b0; end
                POLL_LAST_STEP: begin op_o = OP_STOP; last_o = 1'b1; end
                default:    begin op_o = OP_STOP; last_o = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/imu_poll_sequencer.sv
// ADXL345 bring-up and periodic burst-read sequencer driving a byte-level I2C
// engine; publishes X/Y/Z samples atomically and counts NACK aborts.
module imu_poll_sequencer
    import imu_i2c_pkg::*;
#(
    parameter int unsigned POLL_PERIOD     = 500000,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08,
    parameter logic [6:0]  DEV_ADDR        = 7'h53
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_wdata,
    output logic        cmd_nack,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_ack_err,
    output logic [11:0] AccelX,
    output logic [11:0] AccelY,
    output logic [11:0] AccelZ,
    output logic        sample_strobe,
    output logic        init_done,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_PERIOD - 1);

    state_e           state_q;
    logic [3:0]       step_q;
    logic [2:0]       rd_idx_q;
    logic [5:0][7:0]  buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_valid_q;
    logic [1:0]       cmd_op_q;
    logic [7:0]       cmd_wdata_q;
    logic             cmd_nack_q;
    logic             cmd_last_q;
    logic [11:0]      accel_x_q;
    logic [11:0]      accel_y_q;
    logic [11:0]      accel_z_q;
    logic             strobe_q;
    logic             init_done_q;
    logic [7:0]       err_cnt_q;

    phase_e     rom_phase_s;
    logic [3:0] rom_step_s;
    logic [1:0] rom_op_s;
    logic [7:0] rom_wdata_s;
    logic       rom_nack_s;
    logic       rom_last_s;
    logic [7:0] err_cnt_d;
    logic       rsp_take_s;
    logic       nack_err_s;

    // ROM address points at the command to load on the next transition
    always_comb begin
        rom_phase_s = PH_INIT;
        rom_step_s  = 4'd0;
        err_cnt_d   = sat_inc8(err_cnt_q);
        // a response only counts once the outstanding command has been accepted
        rsp_take_s  = rsp_valid && !cmd_valid_q;
        nack_err_s  = (cmd_op_q == OP_WRITE) && rsp_ack_err;
        case (state_q)
            ST_INIT: begin rom_phase_s = PH_INIT; rom_step_s = step_q + 4'd1; end
            ST_POLL: begin rom_phase_s = PH_POLL; rom_step_s = step_q + 4'd1; end
            ST_WAIT: begin rom_phase_s = init_done_q ? PH_POLL : PH_INIT; rom_step_s = 4'd0; end
            default: begin rom_phase_s = PH_INIT; rom_step_s = 4'd0; end
        endcase
    end

    imu_cmd_rom #(
        .DEV_ADDR        (DEV_ADDR),
        .DATA_FORMAT_VAL (DATA_FORMAT_VAL),
        .POWER_CTL_VAL   (POWER_CTL_VAL)
    ) u_rom (
        .phase_i (rom_phase_s),
        .step_i  (rom_step_s),
        .op_o    (rom_op_s),
        .wdata_o (rom_wdata_s),
        .nack_o  (rom_nack_s),
        .last_o  (rom_last_s)
    );

    // Sequencer FSM with registered command and sample outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= 4'd0;
            rd_idx_q    <= 3'd0;
            buf_q       <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 2'd0;
            cmd_wdata_q <= 8'h00;
            cmd_nack_q  <= 1'b0;
            cmd_last_q  <= 1'b0;
            accel_x_q   <= 12'h000;
            accel_y_q   <= 12'h000;
            accel_z_q   <= 12'h000;
            strobe_q    <= 1'b0;
            init_done_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            strobe_q <= 1'b0;
            if (cmd_valid_q && cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_INIT;
                    step_q      <= 4'd0;
                    cmd_valid_q <= 1'b1;
                    cmd_op_q    <= rom_op_s;
                    cmd_wdata_q <= rom_wdata_s;
                    cmd_nack_q  <= rom_nack_s;
                    cmd_last_q  <= rom_last_s;
                end
                ST_INIT, ST_POLL: begin
                    if (rsp_take_s) begin
                        if (nack_err_s) begin
                            err_cnt_q   <= err_cnt_d;
                            state_q     <= ST_ABORT;
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_STOP;
                            cmd_wdata_q <= 8'h00;
                            cmd_nack_q  <= 1'b0;
                            cmd_last_q  <= 1'b1;
                            if (state_q == ST_INIT) begin
                                init_done_q <= 1'b0;
                            end
                        end else begin
                            if (cmd_op_q == OP_READ) begin
                                buf_q[rd_idx_q] <= rsp_rdata;
                                rd_idx_q        <= rd_idx_q + 3'd1;
                            end
                            if (cmd_last_q) begin
                                if (state_q == ST_INIT) begin
                                    init_done_q <= 1'b1;
                                    state_q     <= ST_WAIT;
                                    cnt_q       <= CNT_LOAD;
                                end else begin
                                    state_q <= ST_PUBLISH;
                                end
                            end else begin
                                step_q      <= step_q + 4'd1;
                                cmd_valid_q <= 1'b1;
                                cmd_op_q    <= rom_op_s;
                                cmd_wdata_q <= rom_wdata_s;
                                cmd_nack_q  <= rom_nack_s;
                                cmd_last_q  <= rom_last_s;
                            end
                        end
                    end
                end
                ST_ABORT: begin
                    if (rsp_take_s) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= init_done_q ? ST_POLL : ST_INIT;
                        step_q      <= 4'd0;
                        rd_idx_q    <= 3'd0;
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= rom_op_s;
                        cmd_wdata_q <= rom_wdata_s;
                        cmd_nack_q  <= rom_nack_s;
                        cmd_last_q  <= rom_last_s;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    accel_x_q <= {buf_q[1][3:0], buf_q[0]};
                    accel_y_q <= {buf_q[3][3:0], buf_q[2]};
                    accel_z_q <= {buf_q[5][3:0], buf_q[4]};
                    strobe_q  <= 1'b1;
                    state_q   <= ST_WAIT;
                    cnt_q     <= CNT_LOAD;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_wdata     = cmd_wdata_q;
    assign cmd_nack      = cmd_nack_q;
    assign AccelX        = accel_x_q;
    assign AccelY        = accel_y_q;
    assign AccelZ        = accel_z_q;
    assign sample_strobe = strobe_q;
    assign init_done     = init_done_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imu_poll_sequencer.sv
// Directed bench for imu_poll_sequencer with a small I2C byte-engine model
// that logs accepted commands and answers after a fixed latency.
module tb_imu_poll_sequencer;
    import imu_i2c_pkg::*;

    localparam int unsigned PERIOD = 100;
    localparam int LOG_N = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_wdata;
    logic        cmd_nack;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_ack_err;
    logic [11:0] AccelX, AccelY, AccelZ;
    logic        sample_strobe;
    logic        init_done;
    logic [7:0]  err_cnt;

    logic        m_rsp_valid = 1'b0;
    logic        m_ack_err = 1'b0;
    logic [7:0]  m_rdata = 8'h00;
    logic        inj_rsp_valid = 1'b0;
    logic        inj_ack_err = 1'b0;

    assign rsp_valid   = m_rsp_valid | inj_rsp_valid;
    assign rsp_ack_err = m_ack_err | inj_ack_err;
    assign rsp_rdata   = m_rdata;

    always #5 clk = ~clk;

    imu_poll_sequencer #(.POLL_PERIOD(PERIOD)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_wdata     (cmd_wdata),
        .cmd_nack      (cmd_nack),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_ack_err   (rsp_ack_err),
        .AccelX        (AccelX),
        .AccelY        (AccelY),
        .AccelZ        (AccelZ),
        .sample_strobe (sample_strobe),
        .init_done     (init_done),
        .err_cnt       (err_cnt)
    );

    // Engine model state
    logic [1:0] log_op [0:LOG_N-1];
    logic [7:0] log_wd [0:LOG_N-1];
    logic       log_nk [0:LOG_N-1];
    int         acc_cnt = 0;
    int         seen = 0;
    bit         pend = 1'b0;
    int         pend_cnt = 0;
    int         rd_ptr = 0;
    int         nack_req = 0;
    int         nack_done = 0;
    logic [7:0] nack_val = 8'h00;
    logic [7:0] rd_tab [0:5];
    int         strobe_cnt = 0;

    int n_checks = 0;
    int n_pass = 0;

    // Log every command the engine accepts
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready && acc_cnt < LOG_N) begin
            log_op[acc_cnt] = cmd_op;
            log_wd[acc_cnt] = cmd_wdata;
            log_nk[acc_cnt] = cmd_nack;
            acc_cnt = acc_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (sample_strobe) strobe_cnt = strobe_cnt + 1;
    end

    // Respond to the outstanding command three edges after acceptance
    always @(negedge clk) begin
        m_rsp_valid = 1'b0;
        m_ack_err   = 1'b0;
        m_rdata     = 8'h00;
        if (reset) begin
            pend   = 1'b0;
            seen   = acc_cnt;
            rd_ptr = 0;
        end else if (seen != acc_cnt) begin
            seen     = acc_cnt;
            pend     = 1'b1;
            pend_cnt = 1;
        end else if (pend) begin
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
            end else begin
                pend = 1'b0;
                m_rsp_valid = 1'b1;
                case (log_op[seen-1])
                    OP_READ: begin
                        m_rdata = rd_tab[rd_ptr];
                        rd_ptr  = (rd_ptr + 1) % 6;
                    end
                    OP_WRITE: begin
                        if (nack_req != nack_done && log_wd[seen-1] == nack_val) begin
                            m_ack_err = 1'b1;
                            nack_done = nack_done + 1;
                        end
                    end
                    OP_STOP: rd_ptr = 0;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_op"}, cmd_op, 0);
        chk({tag, "_cmd_wdata"}, cmd_wdata, 0);
        chk({tag, "_cmd_nack"}, cmd_nack, 0);
        chk({tag, "_accel_x"}, AccelX, 0);
        chk({tag, "_accel_y"}, AccelY, 0);
        chk({tag, "_accel_z"}, AccelZ, 0);
        chk({tag, "_strobe"}, sample_strobe, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic wait_init(input int budget, input string tag);
        int k = 0;
        while (init_done !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        chk(tag, init_done, 1);
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        int k = 0;
        while (sample_strobe !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        chk(tag, sample_strobe, 1);
    endtask

    task automatic wait_err(input logic [7:0] target, input int budget, input string tag);
        int k = 0;
        while (err_cnt !== target && k < budget) begin @(negedge clk); k++; end
        chk(tag, err_cnt, target);
    endtask

    task automatic wait_acc(input int target, input int budget, input string tag);
        int k = 0;
        while (acc_cnt < target && k < budget) begin @(negedge clk); k++; end
        chk(tag, acc_cnt, target);
    endtask

    task automatic check_init_seq(input int base, input string tag);
        logic [1:0] eop [0:9];
        logic [7:0] ewd [0:9];
        eop = '{OP_START, OP_WRITE, OP_WRITE, OP_WRITE, OP_STOP,
                OP_START, OP_WRITE, OP_WRITE, OP_WRITE, OP_STOP};
        ewd = '{8'h00, 8'hA6, 8'h31, 8'h0B, 8'h00, 8'h00, 8'hA6, 8'h2D, 8'h08, 8'h00};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_op%0d", tag, i), log_op[base+i], eop[i]);
            if (eop[i] == OP_WRITE) chk($sformatf("%s_wd%0d", tag, i), log_wd[base+i], ewd[i]);
        end
    endtask

    task automatic check_poll_seq(input int base, input string tag);
        logic [1:0] eop [0:11];
        logic [7:0] ewd [0:11];
        eop = '{OP_START, OP_WRITE, OP_WRITE, OP_START, OP_WRITE, OP_READ,
                OP_READ, OP_READ, OP_READ, OP_READ, OP_READ, OP_STOP};
        ewd = '{8'h00, 8'hA6, 8'h32, 8'h00, 8'hA7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_op%0d", tag, i), log_op[base+i], eop[i]);
            if (eop[i] == OP_WRITE) chk($sformatf("%s_wd%0d", tag, i), log_wd[base+i], ewd[i]);
            if (eop[i] == OP_READ)  chk($sformatf("%s_nk%0d", tag, i), log_nk[base+i], (i == 10) ? 1 : 0);
        end
    endtask

    initial begin
        int base;
        int k;
        bit stable;

        reset = 1'b1;
        cmd_ready = 1'b0;
        rd_tab = '{8'h34, 8'hF2, 8'h01, 8'h00, 8'hFF, 8'h0F};
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Clean bring-up and first poll
        cmd_ready = 1'b1;
        reset = 1'b0;
        wait_init(400, "init1_done");
        k = 0;
        while (!cmd_valid && k < 300) begin @(negedge clk); k++; end
        chk("first_poll_delay", k, PERIOD);
        chk("init1_cmd_count", acc_cnt, 10);
        check_init_seq(0, "init1");
        chk("init1_err_cnt", err_cnt, 0);

        wait_strobe(400, "poll1_strobe");
        chk("poll1_x", AccelX, 12'h234);
        chk("poll1_y", AccelY, 12'h001);
        chk("poll1_z", AccelZ, 12'hFFF);
        check_poll_seq(10, "poll1");
        @(negedge clk);
        chk("poll1_strobe_one_cycle", sample_strobe, 0);
        chk("poll1_strobe_cnt", strobe_cnt, 1);

        // NACK on the register pointer write during a poll
        rd_tab = '{8'hAB, 8'h05, 8'h10, 8'h0C, 8'h00, 8'h08};
        nack_val = 8'h32;
        nack_req = nack_req + 1;
        base = acc_cnt;
        wait_err(8'd1, 400, "poll_nack_err_cnt");
        wait_acc(base + 4, 50, "poll_nack_cmd_count");
        chk("poll_nack_wd", log_wd[base+2], 8'h32);
        chk("poll_nack_stop", log_op[base+3], OP_STOP);
        repeat (5) @(negedge clk);
        chk("poll_nack_no_strobe", strobe_cnt, 1);
        chk("poll_nack_x_held", AccelX, 12'h234);
        chk("poll_nack_y_held", AccelY, 12'h001);
        chk("poll_nack_z_held", AccelZ, 12'hFFF);
        chk("poll_nack_init_done", init_done, 1);
        wait_strobe(400, "poll_retry_strobe");
        chk("poll_retry_x", AccelX, 12'h5AB);
        chk("poll_retry_y", AccelY, 12'hC10);
        chk("poll_retry_z", AccelZ, 12'h800);
        chk("poll_retry_err_cnt", err_cnt, 1);
        check_poll_seq(base + 4, "poll_retry");

        // Backpressure plus a spurious response while waiting
        cmd_ready = 1'b0;
        base = acc_cnt;
        k = 0;
        while (!cmd_valid && k < 300) begin
            @(negedge clk);
            k++;
            inj_rsp_valid = (k == 10);
            inj_ack_err   = (k == 10);
        end
        chk("spurious_wait_len", k, PERIOD);
        chk("spurious_err_cnt", err_cnt, 1);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(cmd_valid === 1'b1 && cmd_op === OP_START)) stable = 1'b0;
        end
        chk("stall_cmd_stable", stable, 1);
        chk("stall_no_accept", acc_cnt, base);
        cmd_ready = 1'b1;
        wait_strobe(400, "stall_poll_strobe");
        chk("stall_poll_count", acc_cnt, base + 12);
        check_poll_seq(base, "stall_poll");
        chk("stall_poll_x", AccelX, 12'h5AB);

        // Reset during the third read, then NACK the first init address byte
        base = acc_cnt;
        wait_acc(base + 8, 400, "third_read_accepted");
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        nack_val = 8'hA6;
        nack_req = nack_req + 1;
        base = acc_cnt;
        reset = 1'b0;
        inj_rsp_valid = 1'b1;
        @(negedge clk);
        inj_rsp_valid = 1'b0;
        wait_err(8'd1, 100, "init_nack_err_cnt");
        chk("init_nack_init_done", init_done, 0);
        wait_acc(base + 3, 50, "init_nack_stop_accept");
        chk("init_nack_op0", log_op[base], OP_START);
        chk("init_nack_wd1", log_wd[base+1], 8'hA6);
        chk("init_nack_stop", log_op[base+2], OP_STOP);
        k = 0;
        while (acc_cnt < base + 4 && k < 300) begin @(negedge clk); k++; end
        chk("init_restart_delay", k, 104);
        wait_init(400, "init2_done");
        check_init_seq(base + 3, "init2");
        chk("init2_err_cnt", err_cnt, 1);
        chk("init2_x_clear", AccelX, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imu_poll_sequencer.md
Name: imu_poll_sequencer

Overview:
- Sequences the byte-level I2C master on the shared I2C_SCL/I2C_SDA bus to bring up the ADXL345 accelerometer (7-bit address 0x53) and then poll it periodically.
- Each poll burst-reads DATAX0..DATAZ1 and publishes atomically updated 12-bit X/Y/Z samples to the probe/register layer.
- Sits between the top level and the I2C byte engine. It owns all register-level transaction ordering and retry.

Parameters:
- POLL_PERIOD, 500000, CLOCK_50 cycles from one poll start to the next (10 ms).
- DATA_FORMAT_VAL, 8'h0B, value written to register 0x31 at init.
- POWER_CTL_VAL, 8'h08, value written to register 0x2D at init (measure mode).
- DEV_ADDR, 7'h53, accelerometer I2C address.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- cmd_valid  out  1  command to I2C byte engine is valid
- cmd_ready  in  1  engine accepts the command; transfer occurs when cmd_valid && cmd_ready
- cmd_op  out  2  command: OP_START, OP_WRITE, OP_READ, OP_STOP
- cmd_wdata  out  8  byte for OP_WRITE
- cmd_nack  out  1  for OP_READ: 1 = master NACKs this byte
- rsp_valid  in  1  one-cycle pulse when a command completes
- rsp_rdata  in  8  byte read (valid with rsp_valid on OP_READ)
- rsp_ack_err  in  1  slave NACKed an OP_WRITE (valid with rsp_valid)
- AccelX  out  12  latest X sample
- AccelY  out  12  latest Y sample
- AccelZ  out  12  latest Z sample
- sample_strobe  out  1  one-cycle pulse when AccelX/Y/Z update
- init_done  out  1  init writes completed successfully
- err_cnt  out  8  saturating count of NACK-aborted transactions

Behaviour:
- Reset values:
  - All outputs 0. cmd_valid=0.
  - State=IDLE. Period counter=0. Byte buffer cleared.
- Command handshake:
  - Exactly one command outstanding at a time.
  - After acceptance (cmd_valid && cmd_ready), cmd_valid drops the next cycle. The sequencer waits for rsp_valid before issuing the next command.
  - cmd_op/cmd_wdata/cmd_nack are held stable while cmd_valid=1.
- State machine:
  - IDLE: enter INIT immediately after reset deasserts.
  - INIT step list:
    - Write 1: START, W {DEV_ADDR,0}, W 0x31, W DATA_FORMAT_VAL, STOP.
    - Write 2: START, W {DEV_ADDR,0}, W 0x2D, W POWER_CTL_VAL, STOP.
    - On completion, init_done=1 and enter WAIT with the counter loaded.
  - WAIT: count POLL_PERIOD-1 down to 0, then enter POLL. The first poll occurs POLL_PERIOD cycles after init_done rises.
  - POLL step list: START, W {DEV_ADDR,0}, W 0x32, START (repeated), W {DEV_ADDR,1}, six READs, STOP.
    - cmd_nack=0 on reads 1-5 and 1 on read 6.
    - Read bytes are stored in buffer b0..b5 in order.
  - PUBLISH (one cycle, after the STOP response):
    - AccelX={b1[3:0],b0}, AccelY={b3[3:0],b2}, AccelZ={b5[3:0],b4}.
    - sample_strobe=1 for this cycle only.
    - Return to WAIT with the counter reloaded.
    - Outputs never show a partial update.
- Error handling:
  - rsp_ack_err=1 on any OP_WRITE response: abort the step list, issue STOP, and increment err_cnt (saturates at 255).
  - Aborted INIT: clear init_done, go to WAIT, then restart INIT (not POLL).
  - Aborted POLL: go to WAIT, then retry POLL. AccelX/Y/Z keep their previous values and no strobe is issued.
- Poll period behaviour: the period is measured from WAIT entry. If a transaction outlasts POLL_PERIOD, polls are not queued; the next one starts after a full WAIT.
- Reset mid-transaction: the sequencer returns to IDLE immediately, drops cmd_valid and ignores any late rsp_valid. The byte engine is reset by the same signal.
- rsp_valid when no command is outstanding is ignored.
- Step sequencing is driven by a step index (0..N) into a per-state command ROM.

Decomposition:
- Package imu_i2c_pkg:
  - OP_* encodings.
  - ADXL345 register constants: REG_DATA_FORMAT=0x31, REG_POWER_CTL=0x2D, REG_DATAX0=0x32.
  - State enum.
  - Step-list length constants.
- Sub-module imu_cmd_rom: combinational map from (phase, step) to {op, wdata, nack, last}. This keeps the FSM free of sequence tables.

Test Plan:
- Reset, then an engine model that always ACKs with cmd_ready=1 → first 5 commands are START, W 0xA6, W 0x31, W 0x0B, STOP; then START, W 0xA6, W 0x2D, W 0x08, STOP; init_done=1.
- POLL_PERIOD=100, model returns bytes 0x34,0x F2,0x01,0x00,0xFF,0x0F → sample_strobe pulse; AccelX=0x234, AccelY=0x001, AccelZ=0xFFF. cmd_nack=1 only on the 6th read; the repeated START carries W 0xA7.
- Model NACKs W 0xA6 in the 1st init write → STOP issued, err_cnt=1, init_done=0, INIT restarts after 100 cycles and then succeeds.
- After a valid sample, NACK W 0x32 during a poll → no strobe, AccelX/Y/Z unchanged, err_cnt increments, next poll succeeds.
- cmd_ready held low 50 cycles → cmd_valid and cmd_op stay stable and no command is skipped. Inject a spurious rsp_valid while idle in WAIT → no state change.
- Assert reset during the 3rd READ → cmd_valid=0 next cycle and all outputs are 0. A late rsp_valid is ignored, and the init sequence re-runs from step 0.
